dmx_buffer_write_arbiter: RTL and testbench

Shares the single write port (port B) of the DMX output universe buffer between two requesters: the host register interface and the scene playback engine. It arbitrates with round-robin fairness, rejects out-of-universe addresses, and runs a blackout sequence that zero-fills the whole universe on command. It sits between the requesters and the DMX output module's `EBR_Addr_B` / `EBR_DataIn_B` / `EBR_WrB` inputs; the output module's read side is untouched.

---
 rtl/dmx_buffer_write_arbiter.sv | 136 +++++++++++++
 tb/tb_dmx_buffer_write_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dmx_buffer_write_arbiter.sv
// Round-robin host/playback arbiter for the DMX buffer write port, with blackout zero-fill.
// Writes and ack/err are registered one cycle after grant; losers keep req pending, fill stalls both.
module dmx_buffer_write_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int MAX_CH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic              host_err,
  input  logic              play_req,
  input  logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_data,
  output logic              play_ack,
  output logic              play_err,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] EBR_Addr_B,
  output logic [DATA_W-1:0] EBR_DataIn_B,
  output logic              EBR_WrB
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(MAX_CH);
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(MAX_CH - 1);

  state_t            state, state_nx;
  logic              last_play, last_play_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              wr_nx, host_ack_nx, host_err_nx, play_ack_nx, play_err_nx, busy_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              host_elig, play_elig, grant_host, grant_play;

  // A requester acked/erred this cycle is still showing the old transaction.
  assign host_elig  = host_req & ~host_ack & ~host_err;
  assign play_elig  = play_req & ~play_ack & ~play_err;
  assign grant_host = host_elig & (~play_elig | last_play);
  assign grant_play = play_elig & (~host_elig | ~last_play);

  always_comb begin
    state_nx     = state;
    last_play_nx = last_play;
    cnt_nx       = cnt;
    wr_nx        = 1'b0;
    addr_nx      = EBR_Addr_B;
    data_nx      = EBR_DataIn_B;
    host_ack_nx  = 1'b0;
    host_err_nx  = 1'b0;
    play_ack_nx  = 1'b0;
    play_err_nx  = 1'b0;
    busy_nx      = 1'b0;
    case (state)
      ARB: begin
        if (clr_start) begin
          // Slot 0 is issued right away; cnt then points at the next slot to write.
          wr_nx   = 1'b1;
          addr_nx = '0;
          data_nx = '0;
          busy_nx = 1'b1;
          if (LAST_SLOT != '0) begin
            cnt_nx   = ADDR_W'(1);
            state_nx = CLEAR;
          end
        end else if (grant_host) begin
          last_play_nx = 1'b0;
          if ({1'b0, host_addr} < LIMIT) begin
            wr_nx       = 1'b1;
            addr_nx     = host_addr;
            data_nx     = host_data;
            host_ack_nx = 1'b1;
          end else begin
            host_err_nx = 1'b1;
          end
        end else if (grant_play) begin
          last_play_nx = 1'b1;
          if ({1'b0, play_addr} < LIMIT) begin
            wr_nx       = 1'b1;
            addr_nx     = play_addr;
            data_nx     = play_data;
            play_ack_nx = 1'b1;
          end else begin
            play_err_nx = 1'b1;
          end
        end
      end
      CLEAR: begin
        wr_nx   = 1'b1;
        addr_nx = cnt;
        data_nx = '0;
        busy_nx = 1'b1;
        if ({1'b0, cnt} == LAST_SLOT) begin
          cnt_nx   = '0;
          state_nx = ARB;
        end else begin
          cnt_nx = cnt + ADDR_W'(1);
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      last_play    <= 1'b1;
      cnt          <= '0;
      EBR_WrB      <= 1'b0;
      EBR_Addr_B   <= '0;
      EBR_DataIn_B <= '0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      play_ack     <= 1'b0;
      play_err     <= 1'b0;
      clr_busy     <= 1'b0;
    end else begin
      state        <= state_nx;
      last_play    <= last_play_nx;
      cnt          <= cnt_nx;
      EBR_WrB      <= wr_nx;
      EBR_Addr_B   <= addr_nx;
      EBR_DataIn_B <= data_nx;
      host_ack     <= host_ack_nx;
      host_err     <= host_err_nx;
      play_ack     <= play_ack_nx;
      play_err     <= play_err_nx;
      clr_busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_dmx_buffer_write_arbiter.sv
// Random requesters, blackout pulses and resets, checked cycle by cycle against a slot-level model.
module tb_dmx_buffer_write_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int MAX_CH = 512;
  localparam int NCYC   = 12000;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_req, play_req, clr_start;
  logic [ADDR_W-1:0] host_addr, play_addr;
  logic [DATA_W-1:0] host_data, play_data;
  logic              host_ack, host_err, play_ack, play_err, clr_busy, EBR_WrB;
  logic [ADDR_W-1:0] EBR_Addr_B;
  logic [DATA_W-1:0] EBR_DataIn_B;

  dmx_buffer_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CH(MAX_CH)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_ack(host_ack), .host_err(host_err),
    .play_req(play_req), .play_addr(play_addr), .play_data(play_data),
    .play_ack(play_ack), .play_err(play_err),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .EBR_Addr_B(EBR_Addr_B), .EBR_DataIn_B(EBR_DataIn_B), .EBR_WrB(EBR_WrB)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference: expected outputs, fairness memory, remaining blackout slots, buffer image.
  bit                m_wr, m_hack, m_herr, m_pack, m_perr, m_busy;
  bit                m_last_play;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_fill_left;
  logic [DATA_W-1:0] exp_mem[MAX_CH];
  logic [DATA_W-1:0] dut_mem[MAX_CH];

  function automatic void model_step();
    bit he, pe, pick_play;
    he = host_req && !(m_hack || m_herr);
    pe = play_req && !(m_pack || m_perr);
    m_hack = 0; m_herr = 0; m_pack = 0; m_perr = 0; m_wr = 0;
    if (rst) begin
      m_busy = 0; m_addr = '0; m_data = '0; m_last_play = 1; m_fill_left = 0;
      return;
    end
    if (m_fill_left > 0) begin
      m_wr = 1; m_busy = 1; m_data = '0;
      m_addr = ADDR_W'(MAX_CH - m_fill_left);
      m_fill_left--;
    end else if (clr_start) begin
      m_wr = 1; m_busy = 1; m_addr = '0; m_data = '0;
      m_fill_left = MAX_CH - 1;
    end else begin
      m_busy = 0;
      if (he || pe) begin
        pick_play = (he && pe) ? !m_last_play : pe;
        m_last_play = pick_play;
        if (int'(pick_play ? play_addr : host_addr) < MAX_CH) begin
          m_wr = 1;
          m_addr = pick_play ? play_addr : host_addr;
          m_data = pick_play ? play_data : host_data;
          if (pick_play) m_pack = 1; else m_hack = 1;
        end else begin
          if (pick_play) m_perr = 1; else m_herr = 1;
        end
      end
    end
    if (m_wr) exp_mem[int'(m_addr)] = m_data;
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0: return ADDR_W'(MAX_CH);
      1: return ADDR_W'(MAX_CH - 1);
      2: return '1;
      3: return '0;
      default: return ADDR_W'($urandom_range(0, MAX_CH - 1));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MAX_CH; i++) begin
      exp_mem[i] = 8'h55;
      dut_mem[i] = 8'h55;
    end
    rst = 1'b1; clr_start = 1'b0;
    host_req = 1'b0; host_addr = '0; host_data = '0;
    play_req = 1'b0; play_addr = '0; play_data = '0;
    model_step();
    @(negedge clk);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      check("outputs",
            {8'b0, EBR_WrB, EBR_Addr_B, EBR_DataIn_B, host_ack, host_err, play_ack, play_err, clr_busy},
            {8'b0, m_wr, m_addr, m_data, m_hack, m_herr, m_pack, m_perr, m_busy});
      if (EBR_WrB === 1'b1 && int'(EBR_Addr_B) < MAX_CH) dut_mem[int'(EBR_Addr_B)] = EBR_DataIn_B;

      if (cyc < 3) rst = 1'b1;
      else if (m_busy) rst = ($urandom_range(0, 1499) == 0);
      else rst = ($urandom_range(0, 2999) == 0);
      clr_start = m_busy ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 199) == 0);

      if (cyc == 4) begin
        host_req = 1'b1; host_addr = ADDR_W'(5); host_data = 8'hA7;
      end else if (host_req && (host_ack || host_err)) begin
        host_req = $urandom_range(0, 1) == 1;
        host_addr = pick_addr(); host_data = DATA_W'($urandom);
      end else if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1; host_addr = pick_addr(); host_data = DATA_W'($urandom);
      end
      if (play_req && (play_ack || play_err)) begin
        play_req = $urandom_range(0, 3) != 0;
        play_addr = pick_addr(); play_data = DATA_W'($urandom);
      end else if (!play_req && $urandom_range(0, 2) == 0) begin
        play_req = 1'b1; play_addr = pick_addr(); play_data = DATA_W'($urandom);
      end

      model_step();
      @(negedge clk);
    end
    for (int i = 0; i < MAX_CH; i++) check("buffer_image", {24'b0, dut_mem[i]}, {24'b0, exp_mem[i]});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
